mips_cpu_harvard: RTL and testbench

MIPS_CPU_HARVARD -- requirements
Module: mips_cpu_harvard

---
 rtl/mips_cpu_harvard.sv | 138 +++++++++++++
 tb/tb_mips_cpu_harvard.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_harvard.sv
// Single-cycle MIPS subset CPU (ADDIU, ADDU, LW, SW, JR) with separate instruction and data ports.
// One instruction retires per enabled clock; JR has one delay slot and a jump to address 0 halts the core.
//
// state  | meaning
// S_RUN  | fetching and retiring one instruction per enabled edge
// S_HALT | PC reached 0; all state frozen until reset
module mips_cpu_harvard (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;
  localparam logic [5:0]  OP_SPECIAL  = 6'h00;
  localparam logic [5:0]  OP_ADDIU    = 6'h09;
  localparam logic [5:0]  OP_LW       = 6'h23;
  localparam logic [5:0]  OP_SW       = 6'h2B;
  localparam logic [5:0]  FUNCT_ADDU  = 6'h21;
  localparam logic [5:0]  FUNCT_JR    = 6'h08;

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] jr_target;
  logic        jr_pending;
  logic [31:0] gpr [32];

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        unused_shamt;

  assign op           = instr_readdata[31:26];
  assign rs           = instr_readdata[25:21];
  assign rt           = instr_readdata[20:16];
  assign rd           = instr_readdata[15:11];
  assign funct        = instr_readdata[5:0];
  assign imm          = instr_readdata[15:0];
  assign unused_shamt = ^instr_readdata[10:6];

  logic is_addiu;
  logic is_addu;
  logic is_lw;
  logic is_sw;
  logic is_jr;

  assign is_addiu = (op == OP_ADDIU);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_addu  = (op == OP_SPECIAL) && (funct == FUNCT_ADDU);
  assign is_jr    = (op == OP_SPECIAL) && (funct == FUNCT_JR);

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_sext;
  logic [31:0] mem_addr;
  logic        running;

  assign rs_val   = (rs == 5'd0) ? 32'd0 : gpr[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : gpr[rt];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign mem_addr = rs_val + imm_sext;
  assign running  = (state == S_RUN);

  assign active         = running;
  assign register_v0    = gpr[2];
  assign instr_address  = pc;
  assign data_address   = mem_addr;
  assign data_writedata = rt_val;
  assign data_read      = is_lw && running && !reset;
  // Store strobe also needs clk_enable, since memory commits it on the coming edge.
  assign data_write     = is_sw && running && !reset && clk_enable;

  logic        wb_en;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;

  always_comb begin
    wb_en   = 1'b0;
    wb_sel  = 5'd0;
    wb_data = 32'd0;
    if (is_addiu) begin
      wb_en   = 1'b1;
      wb_sel  = rt;
      wb_data = rs_val + imm_sext;
    end else if (is_addu) begin
      wb_en   = 1'b1;
      wb_sel  = rd;
      wb_data = rs_val + rt_val;
    end else if (is_lw) begin
      wb_en   = 1'b1;
      wb_sel  = rt;
      wb_data = data_readdata;
    end
  end

  // The delay-slot instruction runs at PC+4, then the saved JR target takes over.
  logic [31:0] pc_next;
  assign pc_next = jr_pending ? jr_target : (pc + 32'd4);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_RUN;
      pc         <= RESET_PC;
      jr_pending <= 1'b0;
      jr_target  <= 32'd0;
      for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
    end else if (clk_enable) begin
      case (state)
        S_RUN: begin
          pc         <= pc_next;
          jr_pending <= is_jr;
          if (is_jr) jr_target <= rs_val;
          if (wb_en && (wb_sel != 5'd0)) gpr[wb_sel] <= wb_data;
          if (pc_next == 32'd0) state <= S_HALT;
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_harvard.sv
// Scoreboard bench for mips_cpu_harvard: an instruction-level reference model predicts each cycle's
// outputs into a queue, and a negedge monitor pops and compares them against the DUT.
module tb_mips_cpu_harvard;

  localparam logic [31:0] ROM_BASE = 32'hBFC0_0000;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  mips_cpu_harvard dut (
    .clk(clk),
    .reset(reset),
    .active(active),
    .register_v0(register_v0),
    .clk_enable(clk_enable),
    .instr_address(instr_address),
    .instr_readdata(instr_readdata),
    .data_address(data_address),
    .data_write(data_write),
    .data_read(data_read),
    .data_writedata(data_writedata),
    .data_readdata(data_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories seen by the DUT
  logic [31:0] rom  [64];
  logic [31:0] dmem [64];
  logic [31:0] rom_off;
  assign rom_off        = instr_address - ROM_BASE;
  assign instr_readdata = (rom_off < 32'd256) ? rom[rom_off[7:2]] : 32'd0;
  assign data_readdata  = dmem[data_address[7:2]];

  // Reference model state
  logic [31:0] m_reg [32];
  logic [31:0] mmem  [64];
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_pend;
  bit          m_halt;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] v0;
    bit          act;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, rs[4:0], rt[4:0], imm};
  endfunction

  function automatic logic [31:0] enc_addu(input int rd, input int rs, input int rt);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, 6'h21};
  endfunction

  function automatic logic [31:0] enc_jr(input int rs);
    return {6'h00, rs[4:0], 15'd0, 6'h08};
  endfunction

  function automatic logic [31:0] fetch(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - ROM_BASE;
    return (off < 32'd256) ? rom[off[7:2]] : 32'd0;
  endfunction

  task automatic load_prog(input logic [31:0] p[$]);
    for (int i = 0; i < 64; i++) rom[i] = 32'd0;
    foreach (p[i]) rom[i] = p[i];
  endtask

  task automatic init_data(input bit rnd);
    logic [31:0] v;
    for (int i = 0; i < 64; i++) begin
      v = rnd ? $urandom : 32'd0;
      dmem[i] = v;
      mmem[i] = v;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_pc   = ROM_BASE;
    m_tgt  = 32'd0;
    m_pend = 1'b0;
    m_halt = 1'b0;
  endtask

  task automatic push_expected(input bit en);
    logic [31:0] ins;
    logic [31:0] sx;
    exp_t e;
    ins     = fetch(m_pc);
    sx      = {{16{ins[15]}}, ins[15:0]};
    e.pc    = m_pc;
    e.v0    = m_reg[2];
    e.act   = !m_halt;
    e.rd    = !m_halt && (ins[31:26] == 6'h23);
    e.wr    = !m_halt && (ins[31:26] == 6'h2B) && en;
    e.addr  = m_reg[ins[25:21]] + sx;
    e.wdata = m_reg[ins[20:16]];
    exp_q.push_back(e);
  endtask

  task automatic model_step(input bit en);
    logic [31:0] ins, a, b, sx, ea, npc;
    bit jr;
    if (!en || m_halt) return;
    ins = fetch(m_pc);
    a   = m_reg[ins[25:21]];
    b   = m_reg[ins[20:16]];
    sx  = {{16{ins[15]}}, ins[15:0]};
    ea  = a + sx;
    jr  = (ins[31:26] == 6'h00) && (ins[5:0] == 6'h08);
    if (ins[31:26] == 6'h09) m_reg[ins[20:16]] = a + sx;
    else if (ins[31:26] == 6'h00 && ins[5:0] == 6'h21) m_reg[ins[15:11]] = a + b;
    else if (ins[31:26] == 6'h23) m_reg[ins[20:16]] = mmem[ea[7:2]];
    else if (ins[31:26] == 6'h2B) mmem[ea[7:2]] = b;
    m_reg[0] = 32'd0;
    npc    = m_pend ? m_tgt : m_pc + 32'd4;
    m_pend = jr;
    if (jr) m_tgt = a;
    m_pc = npc;
    if (npc == 32'd0) m_halt = 1'b1;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic run_cycle(input bit en);
    bit w;
    logic [31:0] wa, wd;
    clk_enable = en;
    push_expected(en);
    #3;
    w  = data_write;
    wa = data_address;
    wd = data_writedata;
    @(posedge clk);
    if (w) dmem[wa[7:2]] = wd;
    #1;
    model_step(en);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    clk_enable = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic run_n(input int n, input bit rnd);
    for (int i = 0; i < n; i++) run_cycle(rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
  endtask

  task automatic run_to_halt(input int max, input bit rnd);
    int n;
    n = 0;
    while (!m_halt && n < max) begin
      run_cycle(rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      n++;
    end
    n_vec++;
    if (!m_halt) begin
      n_err++;
      $display("FAIL halt_timeout: not halted after %0d cycles, required halt", max);
    end
    run_n(5, rnd);
  endtask

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic cmp_field(input string name, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got %h required %h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      cmp_field("instr_address", instr_address, e.pc);
      cmp_field("register_v0", register_v0, e.v0);
      cmp_field("active", {31'd0, active}, {31'd0, e.act});
      cmp_field("data_read", {31'd0, data_read}, {31'd0, e.rd});
      cmp_field("data_write", {31'd0, data_write}, {31'd0, e.wr});
      if (e.rd || e.wr) cmp_field("data_address", data_address, e.addr);
      if (e.wr) cmp_field("data_writedata", data_writedata, e.wdata);
    end
  end

  function automatic logic [31:0] rand_instr();
    int k, op;
    k = $urandom_range(0, 4);
    case (k)
      0: return enc_i(6'h09, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      1: return enc_addu($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      2: return enc_i(6'h23, 0, $urandom_range(0, 7), 16'($urandom_range(0, 63) * 4));
      3: return enc_i(6'h2B, 0, $urandom_range(0, 7), 16'($urandom_range(0, 63) * 4));
      default: begin
        op = $urandom_range(1, 63);
        if (op == 9 || op == 'h23 || op == 'h2B) op = 'h0F;
        return {6'(op), 26'($urandom)};
      end
    endcase
  endfunction

  initial begin
    logic [31:0] p[$];
    reset      = 1'b0;
    clk_enable = 1'b0;
    init_data(1'b0);
    for (int i = 0; i < 64; i++) rom[i] = 32'd0;

    // First instruction after reset
    p = '{enc_i(6'h09, 0, 2, 16'h0005), enc_jr(0), 32'd0};
    load_prog(p);
    do_reset();
    check_eq("reset_pc", instr_address, ROM_BASE);
    check_eq("reset_v0", register_v0, 32'd0);
    check_eq("reset_active", {31'd0, active}, 32'd1);
    run_cycle(1'b1);
    check_eq("addiu_v0", register_v0, 32'h5);
    check_eq("addiu_pc", instr_address, 32'hBFC0_0004);
    run_to_halt(20, 1'b0);

    // ADDU with negative immediate, and $0 stays zero
    p = '{enc_i(6'h09, 0, 3, 16'd7), enc_i(6'h09, 0, 4, 16'hFFFE), enc_addu(2, 3, 4),
          enc_i(6'h09, 0, 0, 16'd9), enc_addu(2, 2, 0), enc_jr(0), 32'd0};
    load_prog(p);
    do_reset();
    run_n(3, 1'b0);
    check_eq("addu_v0", register_v0, 32'h5);
    run_n(2, 1'b0);
    check_eq("zero_reg_v0", register_v0, 32'h5);
    run_to_halt(20, 1'b0);

    // Load
    init_data(1'b0);
    dmem[4] = 32'h1234_5678;
    mmem[4] = 32'h1234_5678;
    p = '{enc_i(6'h23, 0, 2, 16'h0010), enc_jr(0), 32'd0};
    load_prog(p);
    do_reset();
    clk_enable = 1'b1;
    #1;
    check_eq("lw_data_read", {31'd0, data_read}, 32'd1);
    check_eq("lw_addr", data_address, 32'h10);
    run_cycle(1'b1);
    check_eq("lw_v0", register_v0, 32'h1234_5678);
    run_to_halt(20, 1'b0);

    // Store
    p = '{enc_i(6'h09, 0, 5, 16'hABCD), enc_i(6'h2B, 0, 5, 16'h0008), enc_jr(0), 32'd0};
    load_prog(p);
    do_reset();
    run_cycle(1'b1);
    clk_enable = 1'b1;
    #1;
    check_eq("sw_write", {31'd0, data_write}, 32'd1);
    check_eq("sw_addr", data_address, 32'h8);
    check_eq("sw_wdata", data_writedata, 32'hFFFF_ABCD);
    run_to_halt(20, 1'b0);
    check_eq("sw_mem", dmem[2], 32'hFFFF_ABCD);

    // JR delay slot and halt
    p = '{enc_i(6'h09, 0, 2, 16'd1), enc_jr(0), enc_i(6'h09, 2, 2, 16'd1)};
    load_prog(p);
    do_reset();
    run_n(3, 1'b0);
    check_eq("halt_active", {31'd0, active}, 32'd0);
    check_eq("halt_v0", register_v0, 32'd2);
    check_eq("halt_pc", instr_address, 32'd0);
    run_n(10, 1'b0);
    check_eq("halted_v0", register_v0, 32'd2);
    check_eq("halted_pc", instr_address, 32'd0);

    // clk_enable freeze and mid-program reset
    p = {};
    for (int i = 0; i < 8; i++) p.push_back(enc_i(6'h09, 2, 2, 16'd1));
    p.push_back(enc_jr(0));
    p.push_back(32'd0);
    load_prog(p);
    do_reset();
    run_n(3, 1'b0);
    check_eq("pre_freeze_v0", register_v0, 32'd3);
    check_eq("pre_freeze_pc", instr_address, 32'hBFC0_000C);
    for (int i = 0; i < 3; i++) run_cycle(1'b0);
    check_eq("freeze_v0", register_v0, 32'd3);
    check_eq("freeze_pc", instr_address, 32'hBFC0_000C);
    do_reset();
    check_eq("rereset_pc", instr_address, ROM_BASE);
    check_eq("rereset_v0", register_v0, 32'd0);
    check_eq("rereset_active", {31'd0, active}, 32'd1);
    run_to_halt(40, 1'b0);

    // Random programs with random clock enables
    for (int t = 0; t < 20; t++) begin
      p = {};
      for (int i = 0; i < 22; i++) p.push_back(rand_instr());
      p.push_back(enc_jr(0));
      p.push_back(($urandom_range(0, 1) != 0) ? enc_i(6'h09, 2, 2, 16'($urandom)) : rand_instr());
      load_prog(p);
      init_data(1'b1);
      do_reset();
      run_to_halt(200, 1'b1);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
